// File: rtl/ctech_lib_latch_fifo.sv
// Small synchronous FIFO with a latch-based storage array written through a staging register.
// Define CTECH_LIB_LATCH_FIFO_FLOP_EN to build the array from rising-edge flops instead.

`ifndef CTECH_LIB_LATCH_FIFO_FLOP_EN
module ctech_lib_latch_p (
  input  logic clkb,
  input  logic d,
  output logic q
);

  // Transparent while clkb is low, holds while high
  always_latch begin
    if (!clkb) begin
      q <= d;
    end
  end

endmodule
`endif

module ctech_lib_latch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    occ_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] stg_r;
  logic [DEPTH-1:0] we_r;
  logic             full_r;
  logic             empty_r;

  logic             push_acc_s;
  logic             pop_acc_s;
  logic             commit_s;
  logic [CW-1:0]    occ_next_s;
  logic [CW-1:0]    count_next_s;
  logic [DEPTH-1:0] we_next_s;
  logic [DEPTH-1:0] onehot_base_s;
  logic [WIDTH-1:0] mem_s [DEPTH];

  // Acceptance decisions and next occupancy/readable counts
  always_comb begin
    onehot_base_s = {{(DEPTH-1){1'b0}}, 1'b1};
    push_acc_s    = push && !full_r;
    pop_acc_s     = pop && !empty_r;
    commit_s      = |we_r;
    occ_next_s    = occ_r + CW'(push_acc_s) - CW'(pop_acc_s);
    count_next_s  = count_r + CW'(commit_s) - CW'(pop_acc_s);
    if (push_acc_s) begin
      we_next_s = onehot_base_s << wr_ptr_r;
    end else begin
      we_next_s = {DEPTH{1'b0}};
    end
  end

  // Pointer, counter, staging and strobe state; flags are registered from next-state values
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      occ_r    <= {CW{1'b0}};
      count_r  <= {CW{1'b0}};
      stg_r    <= {WIDTH{1'b0}};
      we_r     <= {DEPTH{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_acc_s) begin
        stg_r    <= din;
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      we_r    <= we_next_s;
      occ_r   <= occ_next_s;
      count_r <= count_next_s;
      full_r  <= (occ_next_s == CW'(DEPTH));
      empty_r <= (count_next_s == {CW{1'b0}});
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
`ifdef CTECH_LIB_LATCH_FIFO_FLOP_EN
      // Flop entry loads on the edge that ends the strobe cycle, matching the latch close point
      always_ff @(posedge clk) begin
        if (we_r[gi]) begin
          mem_s[gi] <= stg_r;
        end
      end
`else
      logic clkb_s;
      // Opens only in the low phase of the cycle in which this entry's strobe is set
      assign clkb_s = clk | ~we_r[gi];
      genvar gb;
      for (gb = 0; gb < WIDTH; gb++) begin : g_bit
        ctech_lib_latch_p u_latch (
          .clkb (clkb_s),
          .d    (stg_r[gb]),
          .q    (mem_s[gi][gb])
        );
      end
`endif
    end
  endgenerate

  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;
  assign dout  = empty_r ? {WIDTH{1'b0}} : mem_s[rd_ptr_r];

endmodule

// File: tb/tb_ctech_lib_latch_fifo.sv
// Randomized and directed bench for ctech_lib_latch_fifo against a queue-based reference model.
module tb_ctech_lib_latch_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             push;
  logic [WIDTH-1:0] din;
  logic             full;
  logic             pop;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic [$clog2(DEPTH):0] count;

  int checks;
  int passes;

  logic [WIDTH-1:0] m_ready[$];
  logic             m_pend_v;
  logic [WIDTH-1:0] m_pend_d;
  logic [WIDTH-1:0] next_val;

  ctech_lib_latch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .full  (full),
    .pop   (pop),
    .dout  (dout),
    .empty (empty),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_full();
    return (m_ready.size() + (m_pend_v ? 1 : 0)) == DEPTH;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Model of one clock edge: readable entries, plus at most one entry still being written
  task automatic model_edge(input logic r, input logic pu, input logic po, input logic [WIDTH-1:0] d);
    bit pu_ok;
    bit po_ok;
    if (r) begin
      m_ready.delete();
      m_pend_v = 1'b0;
    end else begin
      pu_ok = pu && !m_full();
      po_ok = po && (m_ready.size() > 0);
      if (po_ok) void'(m_ready.pop_front());
      if (m_pend_v) m_ready.push_back(m_pend_d);
      m_pend_v = pu_ok;
      if (pu_ok) m_pend_d = d;
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] exp_dout;
    exp_dout = (m_ready.size() > 0) ? m_ready[0] : '0;
    check({tag, "_empty"}, 32'(empty), 32'(m_ready.size() == 0));
    check({tag, "_full"},  32'(full),  32'(m_full()));
    check({tag, "_count"}, 32'(count), 32'(m_ready.size()));
    check({tag, "_dout"},  32'(dout),  32'(exp_dout));
  endtask

  task automatic step(input string tag, input logic r, input logic pu, input logic po,
                      input logic [WIDTH-1:0] d);
    rst  = r;
    push = pu;
    pop  = po;
    din  = d;
    @(posedge clk);
    #1;
    model_edge(r, pu, po, d);
    check_all(tag);
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    m_pend_v = 1'b0;
    m_pend_d = '0;
    rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
    #2;

    // Reset then idle
    step("rst", 1'b1, 1'b0, 1'b0, 8'h00);
    step("rst", 1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_dout_zero", 32'(dout), 32'h0);
    check("rst_empty_one", 32'(empty), 32'h1);
    for (int i = 0; i < 10; i++) step("idle", 1'b0, 1'b0, 1'b0, 8'h00);
    check("idle_count", 32'(count), 32'h0);

    // Single push, latency, single pop
    step("p_a5", 1'b0, 1'b1, 1'b0, 8'hA5);
    check("a5_n_empty", 32'(empty), 32'h1);
    step("w_a5", 1'b0, 1'b0, 1'b0, 8'h00);
    check("a5_dout", 32'(dout), 32'hA5);
    check("a5_count", 32'(count), 32'h1);
    step("pop_a5", 1'b0, 1'b0, 1'b1, 8'h00);
    check("a5_pop_dout", 32'(dout), 32'h0);

    // Fill, drop push while full, drain in order
    for (int i = 1; i <= 4; i++) step("fill", 1'b0, 1'b1, 1'b0, 8'(i));
    check("fill_full", 32'(full), 32'h1);
    step("drop5", 1'b0, 1'b1, 1'b0, 8'h05);
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", 32'(dout), 32'(i));
      step("drain", 1'b0, 1'b0, 1'b1, 8'h00);
    end
    check("drain_empty", 32'(empty), 32'h1);

    // Fill then stream with wrap; retry dropped pushes
    next_val = 8'h10;
    for (int i = 0; i < 4; i++) begin
      step("sfill", 1'b0, 1'b1, 1'b0, next_val);
      next_val++;
    end
    for (int i = 0; i < 12; i++) begin
      logic pu;
      pu = !m_full();
      step("stream", 1'b0, pu, 1'b1, next_val);
      if (pu) next_val++;
    end
    while (m_ready.size() > 0 || m_pend_v) step("sdrain", 1'b0, 1'b0, 1'b1, 8'h00);

    // Push and pop together on empty
    step("pp_empty", 1'b0, 1'b1, 1'b1, 8'h3C);
    step("pp_wait", 1'b0, 1'b0, 1'b0, 8'h00);
    check("pp_count", 32'(count), 32'h1);
    check("pp_dout", 32'(dout), 32'h3C);
    step("pp_pop", 1'b0, 1'b0, 1'b1, 8'h00);

    // Reset right after a push
    step("p_77", 1'b0, 1'b1, 1'b0, 8'h77);
    step("rst77", 1'b1, 1'b0, 1'b0, 8'h00);
    check("rst77_count", 32'(count), 32'h0);
    check("rst77_dout", 32'(dout), 32'h0);
    step("p_11", 1'b0, 1'b1, 1'b0, 8'h11);
    step("w_11", 1'b0, 1'b0, 1'b0, 8'h00);
    check("p11_dout", 32'(dout), 32'h11);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
